xoodoo_perm_ctrl_sca: RTL

//  Sequencer wrapped around xoodoo_n_rounds_SCA: accepts a 2-share masked 384-bit Xoodoo state via

---
 rtl/xoodoo_sca_pkg.sv | 43 ++++
 rtl/xoodoo_n_rounds_SCA.sv | 111 +++++++++++
 rtl/xoodoo_perm_ctrl_sca_prng.sv | 30 +++
 rtl/xoodoo_perm_ctrl_sca.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/xoodoo_sca_pkg.sv
// rtl/xoodoo_sca_pkg.sv - shared widths, FSM encoding and Xoodoo helper functions
package xoodoo_sca_pkg;

  localparam int STATE_W     = 384;
  localparam int J_W         = 13;
  localparam int LANE_W      = 32;
  localparam int PLANES      = 3;
  localparam int PLANE_LANES = 4;
  localparam int XS_LANES    = STATE_W / LANE_W;
  localparam int RS_W        = XS_LANES * LANE_W;

  localparam logic [J_W-1:0] J_INIT = 13'h0001;

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

  // Round constants indexed by the one-hot j bit; the top slot is a spare.
  localparam logic [LANE_W-1:0] RC_TABLE [J_W] = '{
    32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
    32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012, 32'h000
  };

  function automatic logic [LANE_W-1:0] rotl32(input logic [LANE_W-1:0] v, input int n);
    return (v << n) | (v >> (LANE_W - n));
  endfunction

  function automatic logic [LANE_W-1:0] rc_from_j(input logic [J_W-1:0] j);
    logic [LANE_W-1:0] c;
    c = '0;
    for (int i = 0; i < J_W; i++) begin
      if (j[i]) c = c | RC_TABLE[i];
    end
    return c;
  endfunction

  function automatic logic [LANE_W-1:0] xorshift32(input logic [LANE_W-1:0] x);
    logic [LANE_W-1:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

endpackage

// File: rtl/xoodoo_n_rounds_SCA.sv
// rtl/xoodoo_n_rounds_SCA.sv - 2-share masked Xoodoo round core, registered output
module xoodoo_n_rounds_SCA
  import xoodoo_sca_pkg::*;
#(
  parameter int roundPerCycle = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] state_in0,
  input  logic [STATE_W-1:0] state_in1,
  input  logic [J_W-1:0]     j_in,
  input  logic [STATE_W-1:0] rs,
  output logic [STATE_W-1:0] state_out0,
  output logic [STATE_W-1:0] state_out1,
  output logic [J_W-1:0]     j_out
);

  function automatic logic [LANE_W-1:0] lane(input logic [STATE_W-1:0] s, input int y, input int x);
    return s[LANE_W*(PLANE_LANES*y+x) +: LANE_W];
  endfunction

  // Theta followed by rho-west; linear, so applied to each share independently.
  function automatic logic [STATE_W-1:0] theta_rho_west(input logic [STATE_W-1:0] s);
    logic [LANE_W-1:0] a [PLANES][PLANE_LANES];
    logic [LANE_W-1:0] p [PLANE_LANES];
    logic [LANE_W-1:0] e [PLANE_LANES];
    logic [STATE_W-1:0] o;
    for (int y = 0; y < PLANES; y++)
      for (int x = 0; x < PLANE_LANES; x++) a[y][x] = lane(s, y, x);
    for (int x = 0; x < PLANE_LANES; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
    for (int x = 0; x < PLANE_LANES; x++)
      e[x] = rotl32(p[(x+3)%4], 5) ^ rotl32(p[(x+3)%4], 14);
    for (int y = 0; y < PLANES; y++)
      for (int x = 0; x < PLANE_LANES; x++) a[y][x] = a[y][x] ^ e[x];
    o = '0;
    for (int x = 0; x < PLANE_LANES; x++) begin
      o[LANE_W*x +: LANE_W]                 = a[0][x];
      o[LANE_W*(PLANE_LANES+x) +: LANE_W]   = a[1][(x+3)%4];
      o[LANE_W*(2*PLANE_LANES+x) +: LANE_W] = rotl32(a[2][x], 11);
    end
    return o;
  endfunction

  function automatic logic [STATE_W-1:0] rho_east(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] o;
    o = s;
    for (int x = 0; x < PLANE_LANES; x++) begin
      o[LANE_W*(PLANE_LANES+x) +: LANE_W]   = rotl32(lane(s, 1, x), 1);
      o[LANE_W*(2*PLANE_LANES+x) +: LANE_W] = rotl32(lane(s, 2, (x+2)%4), 8);
    end
    return o;
  endfunction

  // One masked round; chi uses a DOM-style AND with one fresh mask bit per output bit.
  function automatic logic [2*STATE_W-1:0] round_sca(input logic [STATE_W-1:0] s0,
                                                     input logic [STATE_W-1:0] s1,
                                                     input logic [J_W-1:0]     j,
                                                     input logic [STATE_W-1:0] r);
    logic [STATE_W-1:0] m0, m1, c0, c1;
    logic [LANE_W-1:0]  nb0, nb1, cc0, cc1, rr;
    m0 = theta_rho_west(s0);
    m1 = theta_rho_west(s1);
    m0[LANE_W-1:0] = m0[LANE_W-1:0] ^ rc_from_j(j);
    c0 = m0;
    c1 = m1;
    for (int y = 0; y < PLANES; y++) begin
      for (int x = 0; x < PLANE_LANES; x++) begin
        nb0 = ~lane(m0, (y+1)%3, x);
        nb1 =  lane(m1, (y+1)%3, x);
        cc0 =  lane(m0, (y+2)%3, x);
        cc1 =  lane(m1, (y+2)%3, x);
        rr  =  lane(r, y, x);
        c0[LANE_W*(PLANE_LANES*y+x) +: LANE_W] = lane(m0, y, x) ^ (nb0 & cc0) ^ ((nb0 & cc1) ^ rr);
        c1[LANE_W*(PLANE_LANES*y+x) +: LANE_W] = lane(m1, y, x) ^ (nb1 & cc1) ^ ((nb1 & cc0) ^ rr);
      end
    end
    return {rho_east(c1), rho_east(c0)};
  endfunction

  logic [STATE_W-1:0]   nxt0, nxt1;
  logic [J_W-1:0]       nxtj;
  logic [2*STATE_W-1:0] pair;

  // Chain roundPerCycle masked rounds combinationally, advancing the one-hot selector.
  always_comb begin
    nxt0 = state_in0;
    nxt1 = state_in1;
    nxtj = j_in;
    pair = '0;
    for (int i = 0; i < roundPerCycle; i++) begin
      pair = round_sca(nxt0, nxt1, nxtj, rs);
      nxt0 = pair[STATE_W-1:0];
      nxt1 = pair[2*STATE_W-1:STATE_W];
      nxtj = {nxtj[J_W-2:0], 1'b0};
    end
  end

  // Output register gives the core its single cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_out0 <= '0;
      state_out1 <= '0;
      j_out      <= '0;
    end else begin
      state_out0 <= nxt0;
      state_out1 <= nxt1;
      j_out      <= nxtj;
    end
  end

endmodule

// File: rtl/xoodoo_perm_ctrl_sca_prng.sv
// rtl/xoodoo_perm_ctrl_sca_prng.sv - xorshift32 lane bank for masking randomness (XOODOO_INT_PRNG_EN only)
`ifdef XOODOO_INT_PRNG_EN
module xoodoo_rs_prng
  import xoodoo_sca_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            seed_load,
  input  logic [RS_W-1:0] seed_in,
  output logic [RS_W-1:0] rs
);

  logic [XS_LANES-1:0][LANE_W-1:0] lanes;

  // Lanes step every cycle; a seed load replaces them, forcing all-zero lanes to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < XS_LANES; i++) lanes[i] <= LANE_W'(i + 1);
    end else if (seed_load) begin
      for (int i = 0; i < XS_LANES; i++)
        lanes[i] <= (seed_in[LANE_W*i +: LANE_W] == '0) ? LANE_W'(1) : seed_in[LANE_W*i +: LANE_W];
    end else begin
      for (int i = 0; i < XS_LANES; i++) lanes[i] <= xorshift32(lanes[i]);
    end
  end

  assign rs = lanes;

endmodule
`endif

// File: rtl/xoodoo_perm_ctrl_sca.sv
// rtl/xoodoo_perm_ctrl_sca.sv - masked Xoodoo permutation sequencer; XOODOO_INT_PRNG_EN selects internal PRNG
module xoodoo_perm_ctrl_sca
  import xoodoo_sca_pkg::*;
#(
  parameter int             RPC      = 1,
  parameter int             NROUNDS  = 12,
  parameter int             CORE_LAT = 1,
  parameter logic [J_W-1:0] J_INIT   = xoodoo_sca_pkg::J_INIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_share0,
  input  logic [STATE_W-1:0] in_share1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_share0,
  output logic [STATE_W-1:0] out_share1,
  output logic               busy,
`ifdef XOODOO_INT_PRNG_EN
  input  logic [RS_W-1:0]    seed_in,
  input  logic               seed_load
`else
  input  logic [RS_W-1:0]    rnd_in,
  input  logic               rnd_valid,
  output logic               rnd_ready
`endif
);

  localparam int NITER  = NROUNDS / RPC;
  localparam int ITER_W = (NITER > 1) ? $clog2(NITER) : 1;
  localparam int WCNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  state_t             state, state_nxt;
  logic [STATE_W-1:0] sh0, sh1;
  logic [RS_W-1:0]    rs_q, rs_src, core_rs;
  logic [J_W-1:0]     j_q;
  logic [ITER_W-1:0]  iter;
  logic [WCNT_W-1:0]  wcnt;
  logic [STATE_W-1:0] core_out0, core_out1;
  logic [J_W-1:0]     core_j;
  logic               rs_ok, last_wait, last_iter;

`ifdef XOODOO_INT_PRNG_EN
  logic [RS_W-1:0] prng_rs;

  xoodoo_rs_prng u_prng (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load && (state == IDLE)),
    .seed_in   (seed_in),
    .rs        (prng_rs)
  );

  assign rs_src = prng_rs;
  assign rs_ok  = 1'b1;
`else
  assign rs_src    = rnd_in;
  assign rs_ok     = rnd_valid;
  assign rnd_ready = (state == RUN) && rnd_valid;
`endif

  // Fresh randomness goes straight to the core on the issuing cycle, then from rs_q while waiting.
  assign core_rs   = (state == RUN) ? rs_src : rs_q;
  assign in_ready  = (state == IDLE) && rst_n;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign last_wait = (wcnt == WCNT_W'(CORE_LAT - 1));
  assign last_iter = (iter == ITER_W'(NITER - 1));

  xoodoo_n_rounds_SCA #(
    .roundPerCycle (RPC)
  ) u_core (
    .clk        (clk),
    .rst        (~rst_n),
    .state_in0  (sh0),
    .state_in1  (sh1),
    .j_in       (j_q),
    .rs         (core_rs),
    .state_out0 (core_out0),
    .state_out1 (core_out1),
    .j_out      (core_j)
  );

  // Next-state: RUN waits for randomness, WAIT covers core latency, DONE waits for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (rs_ok) state_nxt = WAIT;
      WAIT:    if (last_wait) state_nxt = last_iter ? DONE : RUN;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and datapath; result and masked state are wiped as soon as the result is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sh0        <= '0;
      sh1        <= '0;
      rs_q       <= '0;
      j_q        <= '0;
      iter       <= '0;
      wcnt       <= '0;
      out_share0 <= '0;
      out_share1 <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh0  <= in_share0;
            sh1  <= in_share1;
            j_q  <= J_INIT;
            iter <= '0;
          end
        end
        RUN: begin
          if (rs_ok) begin
            rs_q <= rs_src;
            wcnt <= '0;
          end
        end
        WAIT: begin
          if (last_wait) begin
            sh0  <= core_out0;
            sh1  <= core_out1;
            j_q  <= core_j;
            iter <= iter + 1'b1;
            if (last_iter) begin
              out_share0 <= core_out0;
              out_share1 <= core_out1;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_share0 <= '0;
            out_share1 <= '0;
            sh0        <= '0;
            sh1        <= '0;
            rs_q       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
